// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        error;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; the head word is read straight from storage.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    assign o_full  = (count_reg == CW'(DEPTH));
    assign o_empty = (count_reg == '0);
    assign o_count = count_reg;
    assign o_data  = mem[rd_ptr_reg];

    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (do_push && !do_pop)
                count_reg <= count_reg + CW'(1);
            else if (do_pop && !do_push)
                count_reg <= count_reg - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr_reg] <= i_data;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Prefetching instruction-fetch front end: pipelined bus reads feed a small
// queue towards decode, with redirect/flush and discard of stale responses.
module ifetch_queue #(
    parameter logic [31:0] INIT_PC         = 32'h1000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_disable,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_req_valid,
    output logic [31:0] o_req_addr,
    input  logic        i_req_ready,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_data,
    input  logic        i_rsp_err,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_error,
    input  logic        i_ready
);
    import ifetch_pkg::*;

    localparam int OCW = $clog2(DEPTH+1);
    localparam int OSW = $clog2(MAX_OUTSTANDING+1);
    localparam int SW  = OCW + 1;

    logic [31:0]    fetch_pc_reg;
    logic [OSW-1:0] outstanding_reg;
    logic [OSW-1:0] outstanding_next;
    logic [OSW-1:0] drop_cnt_reg;
    logic           halted_reg;

    logic [OCW-1:0] occupancy;
    logic           entry_full;
    logic           entry_empty;
    logic           entry_push;
    logic           entry_pop;
    fetch_entry_t   rsp_entry;
    fetch_entry_t   head_entry;

    logic [31:0]    rsp_pc;
    logic [OSW-1:0] addr_count;
    logic           addr_full;
    logic           addr_empty;

    logic           space_ok;
    logic           accept;
    logic           rsp_dec;

    // Stale in-flight requests still hold a reserved slot until their responses
    // are dropped, so they are subtracted from the reservation.
    assign space_ok = (SW'(occupancy) + SW'(outstanding_reg) - SW'(drop_cnt_reg)) < SW'(DEPTH);

    assign o_req_valid = !i_rst && !i_redirect && !i_disable && !halted_reg
                         && (outstanding_reg < OSW'(MAX_OUTSTANDING)) && space_ok;
    assign o_req_addr  = fetch_pc_reg;
    assign accept      = o_req_valid && i_req_ready;
    assign rsp_dec     = i_rsp_valid && (outstanding_reg != '0);

    assign entry_push = i_rsp_valid && (drop_cnt_reg == '0) && !i_redirect;
    assign entry_pop  = !entry_empty && i_ready;

    always_comb begin
        rsp_entry       = '0;
        rsp_entry.pc    = rsp_pc;
        rsp_entry.instr = i_rsp_data;
        rsp_entry.error = i_rsp_err;
    end

    assign outstanding_next = outstanding_reg + OSW'(accept) - OSW'(rsp_dec);

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_entry_q (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_redirect),
        .i_push  (entry_push),
        .i_data  (rsp_entry),
        .i_pop   (entry_pop),
        .o_data  (head_entry),
        .o_full  (entry_full),
        .o_empty (entry_empty),
        .o_count (occupancy)
    );

    // Not cleared on redirect: stale responses still pop their address here.
    sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_addr_q (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (1'b0),
        .i_push  (accept),
        .i_data  (fetch_pc_reg),
        .i_pop   (i_rsp_valid),
        .o_data  (rsp_pc),
        .o_full  (addr_full),
        .o_empty (addr_empty),
        .o_count (addr_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_reg    <= INIT_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            halted_reg      <= 1'b0;
        end else if (i_redirect) begin
            fetch_pc_reg    <= i_redirect_pc & ~32'd1;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= outstanding_next;
            halted_reg      <= 1'b0;
        end else begin
            if (accept) fetch_pc_reg <= fetch_pc_reg + 32'd4;
            outstanding_reg <= outstanding_next;
            if (i_rsp_valid && (drop_cnt_reg != '0))
                drop_cnt_reg <= drop_cnt_reg - OSW'(1);
            if (entry_push && i_rsp_err)
                halted_reg <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (i_rsp_valid) assert (outstanding_reg != '0);
            assert (addr_count == outstanding_reg);
            assert (!(accept && addr_full));
            assert (!(i_rsp_valid && addr_empty));
            assert (!(entry_push && entry_full && !entry_pop));
        end
    end

    assign o_valid = !entry_empty;
    assign o_instr = o_valid ? head_entry.instr : NOP_INSTR;
    assign o_pc    = o_valid ? head_entry.pc : 32'd0;
    assign o_error = o_valid && head_entry.error;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: in-order bus responder, expected-entry scoreboard,
// a per-cycle vector table for start-up/back-pressure, and hand-written corner cases.
module tb_ifetch_queue;
    import ifetch_pkg::*;

    localparam logic [31:0] INIT = 32'h1000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_disable = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_req_valid;
    logic [31:0] o_req_addr;
    logic        i_req_ready = 1'b0;
    logic        i_rsp_valid = 1'b0;
    logic [31:0] i_rsp_data = '0;
    logic        i_rsp_err = 1'b0;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_error;
    logic        i_ready = 1'b0;

    always #5 i_clk = ~i_clk;

    ifetch_queue #(
        .INIT_PC         (INIT),
        .DEPTH           (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_disable     (i_disable),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_req_valid   (o_req_valid),
        .o_req_addr    (o_req_addr),
        .i_req_ready   (i_req_ready),
        .i_rsp_valid   (i_rsp_valid),
        .i_rsp_data    (i_rsp_data),
        .i_rsp_err     (i_rsp_err),
        .o_valid       (o_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_error       (o_error),
        .i_ready       (i_ready)
    );

    typedef struct { logic [31:0] addr; bit stale; int due; } bus_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } exp_t;
    typedef struct {
        bit rst; bit rdy; bit en;
        logic exp_rv; logic [31:0] exp_ra; logic exp_v; logic [31:0] exp_pc;
    } vec_t;

    bus_t bus_q[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_accept = 0;
    bit   rsp_hold = 0;
    bit   want_first = 0;
    bit   saw_err = 0;
    logic [31:0] first_pc = '0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] exp_fetch = INIT;

    logic        obs_rv, obs_v, obs_err;
    logic [31:0] obs_ra, obs_pc, obs_instr;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    function automatic vec_t mk(input bit rst, input bit rdy, input bit en, input logic rv,
                                input logic [31:0] ra, input logic v, input logic [31:0] pc);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.en = en;
        r.exp_rv = rv; r.exp_ra = ra; r.exp_v = v; r.exp_pc = pc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One clock: drive inputs on the falling edge, observe, then advance the model
    // to what the DUT commits on the following rising edge.
    task automatic cycle(input bit rst, input bit redir, input logic [31:0] rpc,
                         input bit dis, input bit rqr, input bit rdy);
        bit   have_rsp;
        bus_t b;
        exp_t e;
        @(negedge i_clk);
        cyc++;
        have_rsp = !rst && !rsp_hold && (bus_q.size() > 0) && (bus_q[0].due <= cyc);
        i_rst         = rst;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_disable     = dis;
        i_req_ready   = rqr;
        i_ready       = rdy;
        i_rsp_valid   = have_rsp;
        i_rsp_data    = have_rsp ? word_of(bus_q[0].addr) : 32'd0;
        i_rsp_err     = have_rsp && (bus_q[0].addr == err_addr);
        #1;
        obs_rv = o_req_valid; obs_ra = o_req_addr; obs_v = o_valid;
        obs_pc = o_pc; obs_instr = o_instr; obs_err = o_error;
        if (rst) begin
            chk("req_valid_in_reset", {31'd0, obs_rv}, 32'd0);
            bus_q.delete();
            exp_q.delete();
            exp_fetch = INIT;
            n_accept = 0;
            return;
        end
        if (!obs_v) chk("nop_when_empty", obs_instr, NOP_INSTR);
        chk("valid_vs_model", {31'd0, obs_v}, {31'd0, exp_q.size() != 0});
        if (redir) begin
            chk("req_valid_on_redirect", {31'd0, obs_rv}, 32'd0);
            foreach (bus_q[i]) bus_q[i].stale = 1;
        end
        if (obs_v && rdy && !redir && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pop_pc", obs_pc, e.pc);
            chk("pop_instr", obs_instr, e.instr);
            chk("pop_err", {31'd0, obs_err}, {31'd0, e.err});
            $display("pop   pc=%h instr=%h err=%0d", obs_pc, obs_instr, obs_err);
            if (want_first) begin first_pc = obs_pc; want_first = 0; end
            if (obs_err) saw_err = 1;
        end
        if (obs_rv && rqr) begin
            chk("req_addr", obs_ra, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            bus_q.push_back('{obs_ra, 1'b0, cyc + 1});
            n_accept++;
        end
        if (have_rsp) begin
            b = bus_q.pop_front();
            if (!b.stale) exp_q.push_back('{b.addr, word_of(b.addr), b.addr == err_addr});
        end
        if (redir) begin
            exp_q.delete();
            exp_fetch = rpc & ~32'd1;
        end
    endtask

    initial begin
        // start-up with a free-running consumer
        vecs[0]  = mk(1, 1, 0, 0, INIT,         0, 0);
        vecs[1]  = mk(1, 1, 1, 0, INIT,         0, 0);
        vecs[2]  = mk(0, 1, 1, 1, INIT,         0, 0);
        vecs[3]  = mk(0, 1, 1, 1, INIT + 4,     0, 0);
        vecs[4]  = mk(0, 1, 1, 1, INIT + 8,     1, INIT);
        vecs[5]  = mk(0, 1, 1, 1, INIT + 12,    1, INIT + 4);
        vecs[6]  = mk(0, 1, 1, 1, INIT + 16,    1, INIT + 8);
        // stalled consumer: fill to DEPTH, then one pop frees exactly one request
        vecs[7]  = mk(1, 0, 0, 0, INIT,         0, 0);
        vecs[8]  = mk(1, 0, 1, 0, INIT,         0, 0);
        vecs[9]  = mk(0, 0, 1, 1, INIT,         0, 0);
        vecs[10] = mk(0, 0, 1, 1, INIT + 4,     0, 0);
        vecs[11] = mk(0, 0, 1, 1, INIT + 8,     1, INIT);
        vecs[12] = mk(0, 0, 1, 1, INIT + 12,    1, INIT);
        vecs[13] = mk(0, 0, 1, 0, INIT + 16,    1, INIT);
        vecs[14] = mk(0, 0, 1, 0, INIT + 16,    1, INIT);
        vecs[15] = mk(0, 1, 1, 0, INIT + 16,    1, INIT);
        vecs[16] = mk(0, 0, 1, 1, INIT + 16,    1, INIT + 4);
        vecs[17] = mk(0, 0, 1, 0, INIT + 20,    1, INIT + 4);
        vecs[18] = mk(0, 0, 1, 0, INIT + 20,    1, INIT + 4);

        for (int k = 0; k < NV; k++) begin
            cycle(vecs[k].rst, 0, 32'd0, 0, 1, vecs[k].rdy);
            if (vecs[k].en) begin
                chk("tbl_req_valid", {31'd0, obs_rv}, {31'd0, vecs[k].exp_rv});
                chk("tbl_req_addr", obs_ra, vecs[k].exp_ra);
                chk("tbl_valid", {31'd0, obs_v}, {31'd0, vecs[k].exp_v});
                chk("tbl_pc", obs_pc, vecs[k].exp_pc);
            end
        end

        // reset with entries still queued
        cycle(0, 0, 32'd0, 0, 0, 1);
        cycle(1, 0, 32'd0, 0, 1, 1);
        err_addr = INIT + 8;
        cycle(0, 0, 32'd0, 0, 1, 1);
        chk("post_rst_valid", {31'd0, obs_v}, 32'd0);
        chk("post_rst_instr", obs_instr, NOP_INSTR);
        chk("post_rst_req_valid", {31'd0, obs_rv}, 32'd1);
        chk("post_rst_req_addr", obs_ra, INIT);

        // bus error halts issue until a redirect
        for (int k = 0; k < 10; k++) cycle(0, 0, 32'd0, 0, 1, 1);
        chk("halt_accepts", n_accept, 4);
        chk("halt_req_valid", {31'd0, obs_rv}, 32'd0);
        chk("halt_saw_error", {31'd0, saw_err}, 32'd1);
        cycle(0, 1, 32'h1000_0100, 0, 1, 1);
        cycle(0, 0, 32'd0, 0, 1, 1);
        chk("resume_req_valid", {31'd0, obs_rv}, 32'd1);
        chk("resume_req_addr", obs_ra, 32'h1000_0100);
        for (int k = 0; k < 6; k++) cycle(0, 0, 32'd0, 0, 1, 1);
        cycle(0, 0, 32'd0, 1, 1, 1);
        chk("disable_req_valid", {31'd0, obs_rv}, 32'd0);

        // redirect with two requests in flight
        rsp_hold = 1;
        for (int k = 0; k < 3; k++) cycle(0, 0, 32'd0, 0, 1, 1);
        cycle(0, 1, 32'h2000_0003, 0, 1, 1);
        rsp_hold = 0;
        want_first = 1;
        cycle(0, 0, 32'd0, 0, 1, 1);
        chk("redir_req_addr", obs_ra, 32'h2000_0002);
        for (int k = 0; k < 8; k++) cycle(0, 0, 32'd0, 0, 1, 1);
        chk("redir_got_first", {31'd0, want_first}, 32'd0);
        chk("redir_first_pc", first_pc, 32'h2000_0002);

        // redirect coinciding with a response and a pop
        for (int k = 0; k < 4; k++) cycle(0, 0, 32'd0, 0, 1, 1);
        rsp_hold = 1;
        cycle(0, 0, 32'd0, 0, 1, 0);
        rsp_hold = 0;
        cycle(0, 1, 32'h3000_0000, 0, 1, 1);
        cycle(0, 0, 32'd0, 0, 1, 1);
        chk("flush_valid", {31'd0, obs_v}, 32'd0);
        chk("flush_req_addr", obs_ra, 32'h3000_0000);
        for (int k = 0; k < 8; k++) cycle(0, 0, 32'd0, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
